// File: rtl/slib_mv_window_filter.sv
// Multi-channel majority-vote filter for slow, noisy single-bit inputs.
// MODE=0: sticky, Q[i] latches once THRESHOLD high samples are seen, until cleared.
// MODE=1: windowed, Q[i] is re-decided every WINDOW samples, with a VALID strobe.
module slib_mv_window_filter #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned THRESHOLD = 10,
    parameter int unsigned CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SAMPLE,
    input  logic                CLEAR,
    input  logic                MODE,
    input  logic [CHANNELS-1:0] D,
    output logic [CHANNELS-1:0] Q,
    output logic                VALID
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    // One extra bit so cnt + D can never wrap.
    localparam logic [CNT_W:0]   THR      = (CNT_W + 1)'(THRESHOLD);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][CNT_W:0]   sum;
    logic [CNT_W-1:0]               win_q, win_d;
    logic                           mode_q, mode_d;
    logic [CHANNELS-1:0]            q_q, q_d;
    logic                           valid_q, valid_d;
    logic                           clr;

    // Widened per-channel count including the current sample, for the window-end decision.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sum[i] = (CNT_W + 1)'(cnt_q[i]) + (CNT_W + 1)'(D[i]);
        end
    end

    // Next-state logic: clear (explicit or mode change) wins over sticky/windowed updates.
    always_comb begin
        cnt_d   = cnt_q;
        win_d   = win_q;
        mode_d  = mode_q;
        q_d     = q_q;
        valid_d = 1'b0;
        clr     = CLEAR | (MODE != mode_q);

        if (clr) begin
            cnt_d  = '0;
            win_d  = '0;
            q_d    = '0;
            mode_d = MODE;
        end else if (!mode_q) begin
            // Sticky: count saturates at THRESHOLD, Q follows one cycle later.
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if ((CNT_W + 1)'(cnt_q[i]) >= THR) begin
                    q_d[i] = 1'b1;
                end else if (SAMPLE && D[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end else if (SAMPLE) begin
            if (win_q == WIN_LAST) begin
                // Window end: the final sample participates in the vote.
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    q_d[i] = (sum[i] >= THR);
                end
                cnt_d   = '0;
                win_d   = '0;
                valid_d = 1'b1;
            end else begin
                win_d = win_q + CNT_W'(1);
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(D[i]);
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            win_q   <= '0;
            mode_q  <= 1'b0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_slib_mv_window_filter.sv
// Bench for slib_mv_window_filter: two instances (WINDOW=8/THRESHOLD=5 and
// WINDOW=1/THRESHOLD=1) share the stimulus and are checked every cycle
// against a vote-counting reference model.
module tb_slib_mv_window_filter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SAMPLE = 1'b0;
    logic       CLEAR = 1'b0;
    logic       MODE = 1'b0;
    logic [1:0] D = 2'b00;
    logic [1:0] Q8, Q1;
    logic       V8, V1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = WINDOW 8, index 1 = WINDOW 1.
    int       w_p [2] = '{8, 1};
    int       t_p [2] = '{5, 1};
    int       hits[2][2];
    int       pos [2];
    bit [1:0] m_q [2];
    bit       m_v [2];
    bit       m_mode[2];

    always #5 CLK = ~CLK;

    slib_mv_window_filter #(
        .CHANNELS (2),
        .WINDOW   (8),
        .THRESHOLD(5)
    ) u_dut8 (
        .CLK   (CLK),
        .RST   (RST),
        .SAMPLE(SAMPLE),
        .CLEAR (CLEAR),
        .MODE  (MODE),
        .D     (D),
        .Q     (Q8),
        .VALID (V8)
    );

    slib_mv_window_filter #(
        .CHANNELS (2),
        .WINDOW   (1),
        .THRESHOLD(1)
    ) u_dut1 (
        .CLK   (CLK),
        .RST   (RST),
        .SAMPLE(SAMPLE),
        .CLEAR (CLEAR),
        .MODE  (MODE),
        .D     (D),
        .Q     (Q1),
        .VALID (V1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hits[k][0] = 0;
            hits[k][1] = 0;
            pos[k]     = 0;
            m_q[k]     = '0;
            m_v[k]     = 1'b0;
            m_mode[k]  = 1'b0;
        end
    endtask

    // One clock edge of the reference: hits = high samples seen so far
    // (sticky: accepted highs, capped; windowed: highs in the open window).
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0;
            if (CLEAR || (MODE != m_mode[k])) begin
                hits[k][0] = 0;
                hits[k][1] = 0;
                pos[k]     = 0;
                m_q[k]     = '0;
                m_mode[k]  = MODE;
            end else if (!m_mode[k]) begin
                for (int c = 0; c < 2; c++) begin
                    if (hits[k][c] >= t_p[k]) m_q[k][c] = 1'b1;
                    else if (SAMPLE && D[c]) hits[k][c]++;
                end
            end else if (SAMPLE) begin
                for (int c = 0; c < 2; c++) hits[k][c] += int'(D[c]);
                pos[k]++;
                if (pos[k] == w_p[k]) begin
                    for (int c = 0; c < 2; c++) m_q[k][c] = (hits[k][c] >= t_p[k]);
                    hits[k][0] = 0;
                    hits[k][1] = 0;
                    pos[k]     = 0;
                    m_v[k]     = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("q_w8", 32'(Q8), 32'(m_q[0]));
        check_val("valid_w8", 32'(V8), 32'(m_v[0]));
        check_val("q_w1", 32'(Q1), 32'(m_q[1]));
        check_val("valid_w1", 32'(V1), 32'(m_v[1]));
    endtask

    // Advance one edge, then compare 1 time unit later; inputs change after that.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic s, input logic [1:0] d, input logic c, input logic m);
        SAMPLE = s;
        D      = d;
        CLEAR  = c;
        MODE   = m;
        tick();
    endtask

    // Pulse RST between edges; outputs must drop without any clock edge.
    task automatic async_reset(input string tag);
        #1;
        RST = 1'b1;
        #1;
        model_reset();
        check_val({tag, "_q"}, 32'({Q8, Q1}), 32'({m_q[0], m_q[1]}));
        check_val({tag, "_valid"}, 32'({V8, V1}), 32'(0));
        #1;
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0] ch0_pat;
        logic [7:0] ch1_pat;
        model_reset();
        #2;
        check_val("reset_q", 32'({Q8, Q1}), 32'(0));
        check_val("reset_valid", 32'({V8, V1}), 32'(0));
        #1;
        RST = 1'b0;

        // Sticky, D=01: Q[0] rises one edge after the 5th accepted sample.
        for (int i = 0; i < 5; i++) drive(1'b1, 2'b01, 1'b0, 1'b0);
        check_val("sticky_before", 32'(Q8), 32'(0));
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        check_val("sticky_rise", 32'(Q8), 32'(1));
        for (int i = 0; i < 10; i++) drive(1'b1, 2'b01, 1'b0, 1'b0);
        check_val("sticky_hold", 32'(Q8), 32'(1));
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        check_val("sticky_clear", 32'(Q8), 32'(0));

        // Sticky to Q=11, then asynchronous reset mid-cycle.
        for (int i = 0; i < 6; i++) drive(1'b1, 2'b11, 1'b0, 1'b0);
        check_val("sticky_both", 32'(Q8), 32'(3));
        async_reset("async_rst");

        // Windowed: first cycle with MODE=1 is the mode-change clear.
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        ch0_pat = 8'b1111_1000;
        ch1_pat = 8'b0000_1111;
        for (int i = 0; i < 8; i++) drive(1'b1, {ch1_pat[i], ch0_pat[i]}, 1'b0, 1'b1);
        check_val("win1_valid", 32'(V8), 32'(1));
        check_val("win1_q", 32'(Q8), 32'(1));
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b11, 1'b0, 1'b1);
            drive(1'b1, 2'b00, 1'b0, 1'b1);
            if (i < 7) check_val("win2_hold", 32'(Q8), 32'(1));
        end
        check_val("win2_q", 32'(Q8), 32'(0));

        // CLEAR coincident with the 8th sample of a window.
        for (int i = 0; i < 7; i++) drive(1'b1, 2'b11, 1'b0, 1'b1);
        drive(1'b1, 2'b11, 1'b1, 1'b1);
        check_val("clr_end_valid", 32'(V8), 32'(0));
        check_val("clr_end_q", 32'(Q8), 32'(0));
        for (int i = 0; i < 7; i++) drive(1'b1, 2'b11, 1'b0, 1'b1);
        check_val("clr_newwin_wait", 32'(V8), 32'(0));
        drive(1'b1, 2'b11, 1'b0, 1'b1);
        check_val("clr_newwin_valid", 32'(V8), 32'(1));

        // Mode switch 0->1 while sticky Q=11.
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        check_val("modesw_q", 32'(Q8), 32'(0));
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b10, 1'b0, 1'b1);
        check_val("modesw_valid", 32'(V8), 32'(1));

        // Randomized traffic with occasional clears, mode flips and resets.
        for (int i = 0; i < 3000; i++) begin
            logic m;
            m = MODE;
            if ($urandom_range(0, 149) == 0) m = ~m;
            drive(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 63) == 0), m);
            if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slib_mv_window_filter.md
# slib_mv_window_filter

Multi-channel majority-vote filter for the APB UART input path and other slow, noisy single-bit inputs such as modem-status lines. It generalises the single-channel sticky filter in two ways. It handles CHANNELS independent inputs with one shared sample strobe. It also adds a runtime-selectable windowed mode, in which each output is re-decided every WINDOW samples instead of latching until cleared.

## Interface
Parameters:
- CHANNELS, 4, number of independent filtered bits (≥1)
- WINDOW, 16, samples per decision window in windowed mode (≥1)
- THRESHOLD, 10, high-sample count needed to assert Q (1 ≤ THRESHOLD ≤ WINDOW)
- CNT_W, $clog2(WINDOW+1), width of per-channel and window counters

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- SAMPLE  in  1  sample strobe shared by all channels, one cycle per sample
- CLEAR  in  1  synchronous clear of all state
- MODE  in  1  0 = sticky, 1 = windowed
- D  in  CHANNELS  raw inputs, one bit per channel
- Q  out  CHANNELS  filtered outputs
- VALID  out  1  one-cycle strobe at the end of each window, windowed mode only

## Operation
- State:
  - per-channel counter cnt[i], CNT_W bits
  - shared window counter win, CNT_W bits, range 0..WINDOW-1
  - registered mode_q
  - Q register, VALID register
- Reset values: cnt = 0, win = 0, Q = 0, VALID = 0, mode_q = 0.
- Clear condition: clr = CLEAR | (MODE != mode_q).
  - clr has priority over all other updates in its cycle.
  - It zeroes cnt, win, Q and VALID, and loads mode_q <= MODE.
  - A mode change therefore always restarts from a clean state.
- Sticky mode (mode_q = 0), per channel:
  - If cnt[i] ≥ THRESHOLD: Q[i] <= 1 and cnt[i] holds. The count saturates at THRESHOLD.
  - Else if SAMPLE & D[i]: cnt[i] <= cnt[i] + 1.
  - Q[i] stays 1 until clr.
  - win stays 0 and VALID stays 0.
- Windowed mode (mode_q = 1):
  - On SAMPLE with win < WINDOW-1:
    - win <= win + 1.
    - For each channel with D[i] = 1, cnt[i] <= cnt[i] + 1.
  - On SAMPLE with win = WINDOW-1 (window end):
    - Q[i] <= ((cnt[i] + D[i]) ≥ THRESHOLD), so the final sample counts.
    - cnt <= 0, win <= 0, VALID <= 1.
  - Q holds between window ends. VALID is 0 in every cycle that is not a window end.
  - WINDOW = 1: every SAMPLE is a window end.
- Width rules:
  - cnt never exceeds WINDOW, so CNT_W bits is sufficient.
  - The sum cnt + D is computed in CNT_W+1 bits. No wrap is permitted.
- SAMPLE is ignored while clr is active.

## Timing
- All outputs are registered. There is no combinational path from any input to Q or VALID.
- Sticky mode:
  - Sample accepted at edge k makes cnt = THRESHOLD.
  - Q rises at edge k+1, one cycle after the count reaches THRESHOLD.
- Windowed mode: Q and VALID update at the same edge that accepts the final sample of a window.
- VALID is exactly one cycle wide.
- Back-to-back SAMPLE strobes every cycle are supported at full rate.
- Asynchronous RST forces the reset values immediately, mid-window or otherwise. Operation resumes in sticky mode unless MODE = 1.
  - With MODE = 1 held through reset, the first cycle after reset sees MODE != mode_q and performs a clear. Window counting starts the following cycle.
- CLEAR in the same cycle as a window-end SAMPLE: clear wins. Q = 0, VALID = 0, and that sample is discarded.

## Test plan
Default parameters unless stated: CHANNELS=2, WINDOW=8, THRESHOLD=5.
- Reset: assert RST mid-operation with Q=2'b11 -> Q=0 and VALID=0 immediately, with no clock edge required.
- Sticky mode, D=2'b01, 5 consecutive SAMPLEs:
  - Q[0] rises exactly one cycle after the 5th accepted sample; Q[1] stays 0.
  - 10 further samples -> Q[0] stays 1 and cnt[0] holds at 5.
  - CLEAR -> Q=0 the next cycle.
- Windowed mode:
  - Window 1: ch0 high on 5 of 8 samples, the 5th being the last sample; ch1 high on 4 of 8.
    -> VALID pulses once at the 8th-sample edge, Q=2'b01 at that same edge.
  - Next window all-low -> Q=2'b00 at the following window end. Q holds 2'b01 in between.
- Window boundary with CLEAR: CLEAR coincident with the 8th SAMPLE -> VALID stays 0 and Q=0. A new full 8-sample window is then required before the next VALID.
- Mode switch: toggle MODE 0->1 while sticky Q=2'b11 -> internal clear gives Q=0 next cycle, and the first VALID comes exactly 8 SAMPLEs later.
- Edge parameters: WINDOW=1, THRESHOLD=1 -> Q mirrors D at each SAMPLE, and VALID pulses on every SAMPLE.
